// File: rtl/adc_spi_xfer_if.sv
// Bus between the touch-screen ADC transfer engine, its sequencer and the ADC pins.
// Ports: Ena_trans/ADC_DOUT toward the engine; ADC_DCLK/ADC_DIN, X_COORD/Y_COORD, Busy/Done from it.
// slave = the transfer engine; master = sequencer/ADC side that drives requests and serial data.
interface adc_spi_xfer_if;
  logic        Ena_trans;
  logic        ADC_DOUT;
  logic        ADC_DCLK;
  logic        ADC_DIN;
  logic [11:0] X_COORD;
  logic [11:0] Y_COORD;
  logic        Busy;
  logic        Done;

  modport master (
    output Ena_trans, ADC_DOUT,
    input  ADC_DCLK, ADC_DIN, X_COORD, Y_COORD, Busy, Done
  );

  modport slave (
    input  Ena_trans, ADC_DOUT,
    output ADC_DCLK, ADC_DIN, X_COORD, Y_COORD, Busy, Done
  );
endinterface

// File: rtl/adc_spi_xfer.sv
// Touch-screen ADC SPI engine: one X frame then one Y frame (24 DCLKs each), publishes both results with a Done pulse.
// Latency: Done 96*CLK_DIV cycles after the FRAME_X entry edge (192*CLK_DIV with ADC_AVG_EN); all outputs registered.
// Backpressure: none; Ena_trans is a level request, dropping it mid-frame aborts, and it must fall to re-arm.
// Ports: CLK, RST_n (async active-low), bus (adc_spi_xfer_if.slave).
// Macro ADC_AVG_EN: convert each axis twice (X, X, Y, Y) and publish the truncated mean of each pair.
module adc_spi_xfer #(
  parameter int         CLK_DIV = 25,
  parameter logic [7:0] CMD_X   = 8'hD0,
  parameter logic [7:0] CMD_Y   = 8'h90
) (
  input  logic          CLK,
  input  logic          RST_n,
  adc_spi_xfer_if.slave bus
);

`ifdef ADC_AVG_EN
  typedef enum logic [2:0] {IDLE, FRAME_X, FRAME_X2, FRAME_Y, FRAME_Y2, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FRAME_X, FRAME_Y, DONE} state_t;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic        arm_q, arm_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        half_q, half_d;
  logic [11:0] shift_q, shift_d;
  logic [11:0] x_sh_q, x_sh_d;
`ifdef ADC_AVG_EN
  logic [11:0] x1_q, x1_d;
  logic [11:0] y1_q, y1_d;
`endif
  logic        dclk_q, dclk_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] x_coord_q, x_coord_d;
  logic [11:0] y_coord_q, y_coord_d;

  logic        start;
  logic        tick;
  logic        frame_end;
  logic        frame_d;
  logic [7:0]  cmd_sel;

`ifdef ADC_AVG_EN
  // 13-bit sum so the carry is kept before halving.
  function automatic logic [11:0] avg2(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return 12'(sum >> 1);
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    div_d     = div_q;
    bit_d     = bit_q;
    half_d    = half_q;
    shift_d   = shift_q;
    x_sh_d    = x_sh_q;
`ifdef ADC_AVG_EN
    x1_d      = x1_q;
    y1_d      = y1_q;
`endif
    x_coord_d = x_coord_q;
    y_coord_d = y_coord_q;

    tick      = (div_q == DIV_LAST);
    frame_end = tick && half_q && (bit_q == 5'd23);
    start     = (state_q == IDLE) && bus.Ena_trans && arm_q;

    // Arm is a level: any cycle with the request low re-arms; only a start consumes it.
    if (!bus.Ena_trans)  arm_d = 1'b1;
    else if (start)      arm_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FRAME_X;
          div_d   = '0;
          bit_d   = '0;
          half_d  = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (!bus.Ena_trans) begin
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
          half_d  = 1'b0;
        end else begin
          if (tick) begin
            div_d = '0;
            if (half_q) begin
              half_d = 1'b0;
              bit_d  = (bit_q == 5'd23) ? 5'd0 : bit_q + 5'd1;
            end else begin
              half_d = 1'b1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end

          // Capture on the edge that raises DCLK, result bits only (k=8 is the ADC busy clock).
          if (!half_q && tick && bit_q >= 5'd9 && bit_q <= 5'd20)
            shift_d = {shift_q[10:0], bus.ADC_DOUT};

          if (frame_end) begin
            case (state_q)
`ifdef ADC_AVG_EN
              FRAME_X:  begin x1_d = shift_q; state_d = FRAME_X2; end
              FRAME_X2: begin x_sh_d = avg2(x1_q, shift_q); state_d = FRAME_Y; end
              FRAME_Y:  begin y1_d = shift_q; state_d = FRAME_Y2; end
              default: begin
                state_d   = DONE;
                x_coord_d = x_sh_q;
                y_coord_d = avg2(y1_q, shift_q);
              end
`else
              FRAME_X: begin x_sh_d = shift_q; state_d = FRAME_Y; end
              default: begin
                state_d   = DONE;
                x_coord_d = x_sh_q;
                y_coord_d = shift_q;
              end
`endif
            endcase
          end
        end
      end
    endcase

    // Pin outputs follow the next state so an abort or frame change shows on the same edge.
    frame_d = (state_d != IDLE) && (state_d != DONE);
`ifdef ADC_AVG_EN
    cmd_sel = (state_d == FRAME_X || state_d == FRAME_X2) ? CMD_X : CMD_Y;
`else
    cmd_sel = (state_d == FRAME_X) ? CMD_X : CMD_Y;
`endif
    dclk_d = frame_d && half_d;
    // Command is sent MSB first during bits 0..7; bit_d only changes at the DCLK falling point.
    din_d  = frame_d && (bit_d[4:3] == 2'b00) && cmd_sel[~bit_d[2:0]];
    busy_d = frame_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      arm_q     <= 1'b1;
      div_q     <= '0;
      bit_q     <= '0;
      half_q    <= 1'b0;
      shift_q   <= '0;
      x_sh_q    <= '0;
`ifdef ADC_AVG_EN
      x1_q      <= '0;
      y1_q      <= '0;
`endif
      dclk_q    <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_coord_q <= '0;
      y_coord_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      half_q    <= half_d;
      shift_q   <= shift_d;
      x_sh_q    <= x_sh_d;
`ifdef ADC_AVG_EN
      x1_q      <= x1_d;
      y1_q      <= y1_d;
`endif
      dclk_q    <= dclk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x_coord_q <= x_coord_d;
      y_coord_q <= y_coord_d;
    end
  end

  assign bus.ADC_DCLK = dclk_q;
  assign bus.ADC_DIN  = din_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.X_COORD  = x_coord_q;
  assign bus.Y_COORD  = y_coord_q;

endmodule

// File: tb/tb_adc_spi_xfer.sv
// Testbench for adc_spi_xfer: ADC serial model plus scenario tasks with inline checks.
// Transfer latency is counted in CLK edges from the edge after which Ena_trans is raised.
// Works with or without ADC_AVG_EN (frame count and expected results follow the macro).
module tb_adc_spi_xfer;
  localparam int         D  = 2;
  localparam logic [7:0] CX = 8'hD0;
  localparam logic [7:0] CY = 8'h90;
`ifdef ADC_AVG_EN
  localparam int NFR = 4;
`else
  localparam int NFR = 2;
`endif
  localparam int LAT = 1 + NFR * 48 * D;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;

  adc_spi_xfer_if bus();

  adc_spi_xfer #(.CLK_DIV(D), .CMD_X(CX), .CMD_Y(CY)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Per-frame result the ADC model returns, in frame order.
  logic [11:0] frame_val[4];
  bit          tail_one = 1'b0;

  int   rcount = 0;
  bit   dclk_prev = 1'b0, busy_prev = 1'b0, din_prev = 1'b0;
  int   glitches = 0, hi_cycles = 0, done_cnt = 0;
  logic din_bits[$];

  // ADC serial behaviour: bit k of frame f is presented from the DCLK fall that starts it.
  function automatic logic model_bit(int r);
    int k, f;
    k = r % 24;
    f = r / 24;
    if (f < NFR && k >= 9 && k <= 20) return frame_val[f][20 - k];
    if (k >= 21 && tail_one) return 1'b1;
    return 1'(0 + $urandom);
  endfunction

  always @(negedge CLK) begin
    if (bus.Done) done_cnt++;
    if (bus.ADC_DCLK) hi_cycles++;
    if (!bus.Busy) begin
      rcount = 0;
      dclk_prev = 1'b0;
      bus.ADC_DOUT = 1'(0 + $urandom);
    end else begin
      if (busy_prev && (bus.ADC_DIN !== din_prev) && !(dclk_prev && !bus.ADC_DCLK)) glitches++;
      if (bus.ADC_DCLK && !dclk_prev) begin
        din_bits.push_back(bus.ADC_DIN);
        rcount++;
      end
      if (!bus.ADC_DCLK && dclk_prev) bus.ADC_DOUT = model_bit(rcount);
      dclk_prev = bus.ADC_DCLK;
    end
    busy_prev = bus.Busy;
    din_prev  = bus.ADC_DIN;
  end

  // Expected published values for two samples per axis (second ignored without averaging).
  function automatic logic [11:0] exp_val(logic [11:0] a, logic [11:0] b);
    int s;
    if (NFR == 2) return a;
    s = int'(a) + int'(b);
    return 12'(s / 2);
  endfunction

  task automatic load_frames(input logic [11:0] xa, xb, ya, yb);
    if (NFR == 2) begin
      frame_val[0] = xa; frame_val[1] = ya; frame_val[2] = '0; frame_val[3] = '0;
    end else begin
      frame_val[0] = xa; frame_val[1] = xb; frame_val[2] = ya; frame_val[3] = yb;
    end
  endtask

  // Re-arm, raise the request and wait (bounded) for Done; lat=-1 on timeout.
  task automatic run_xfer(output int lat);
    din_bits.delete();
    glitches = 0; hi_cycles = 0; done_cnt = 0;
    bus.Ena_trans = 1'b0;
    @(posedge CLK); #1;
    hi_cycles = 0;
    bus.Ena_trans = 1'b1;
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge CLK); #1;
      if (bus.Done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.Ena_trans = 1'b0;
    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    @(posedge CLK); #1;
    bus.Ena_trans = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    checks++;
    if (bus.Busy !== 1'b1) begin failures++; $display("FAIL reset_prebusy got=%b exp=1", bus.Busy); end
    #2 RST_n = 1'b0;
    bus.Ena_trans = 1'b0;
    #1;
    checks++;
    if ({bus.ADC_DCLK, bus.ADC_DIN, bus.Busy, bus.Done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl got dclk/din/busy/done=%b exp=0000",
               {bus.ADC_DCLK, bus.ADC_DIN, bus.Busy, bus.Done});
    end
    checks++;
    if ({bus.X_COORD, bus.Y_COORD} !== 24'h0) begin
      failures++; $display("FAIL reset_coord got=%h/%h exp=000/000", bus.X_COORD, bus.Y_COORD);
    end
    @(posedge CLK); #1 RST_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge CLK);
      if (bus.Busy !== 1'b0 || bus.ADC_DCLK !== 1'b0 || bus.Done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_idle active_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_nominal();
    int lat, bad;
    logic [7:0] cmd;
    logic e;
    tail_one = 1'b0;
    load_frames(12'hA5C, 12'hA5C, 12'h3F1, 12'h3F1);
    run_xfer(lat);
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL nom_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (bus.X_COORD !== 12'hA5C || bus.Y_COORD !== 12'h3F1) begin
      failures++; $display("FAIL nom_coord got=%h/%h exp=a5c/3f1", bus.X_COORD, bus.Y_COORD);
    end
    checks++;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL nom_busy_in_done got=%b exp=0", bus.Busy); end
    checks++;
    if (din_bits.size() != NFR * 24) begin
      failures++; $display("FAIL nom_dclk_rises got=%0d exp=%0d", din_bits.size(), NFR * 24);
    end
    bad = 0;
    for (int i = 0; i < din_bits.size() && i < NFR * 24; i++) begin
      cmd = (i / 24 < NFR / 2) ? CX : CY;
      e = (i % 24 < 8) ? cmd[7 - (i % 24)] : 1'b0;
      if (din_bits[i] !== e) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL nom_din_bits wrong=%0d exp=0", bad); end
    checks++;
    if (hi_cycles != NFR * 24 * D) begin
      failures++; $display("FAIL nom_dclk_high got=%0d exp=%0d", hi_cycles, NFR * 24 * D);
    end
    checks++;
    if (glitches != 0) begin failures++; $display("FAIL nom_din_timing got=%0d exp=0", glitches); end
    @(posedge CLK); #1;
    checks++;
    if (bus.Done !== 1'b0 || done_cnt != 1) begin
      failures++; $display("FAIL nom_done_pulse got done=%b count=%0d exp=0/1", bus.Done, done_cnt);
    end
    bus.Ena_trans = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    logic [11:0] xa, xb, ya, yb;
    tail_one = 1'b0;
    for (int n = 0; n < 3; n++) begin
      xa = 12'($urandom); xb = 12'($urandom); ya = 12'($urandom); yb = 12'($urandom);
      load_frames(xa, xb, ya, yb);
      run_xfer(lat);
      checks++;
      if (lat != LAT || bus.X_COORD !== exp_val(xa, xb) || bus.Y_COORD !== exp_val(ya, yb)) begin
        failures++;
        $display("FAIL rand%0d got lat=%0d coord=%h/%h exp lat=%0d coord=%h/%h", n, lat,
                 bus.X_COORD, bus.Y_COORD, LAT, exp_val(xa, xb), exp_val(ya, yb));
      end
      bus.Ena_trans = 1'b0;
    end
  endtask

  task automatic test_no_retrigger();
    int lat;
    logic [11:0] xa, ya;
    xa = 12'($urandom); ya = 12'($urandom);
    load_frames(xa, xa, ya, ya);
    bus.Ena_trans = 1'b0;
    @(posedge CLK); #1;
    done_cnt = 0;
    bus.Ena_trans = 1'b1;
    repeat (500) @(posedge CLK);
    #1;
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL noretrig_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL noretrig_idle got busy=%b exp=0", bus.Busy); end
    xa = 12'($urandom); ya = 12'($urandom);
    load_frames(xa, xa, ya, ya);
    run_xfer(lat);
    checks++;
    if (lat != LAT || bus.X_COORD !== xa || bus.Y_COORD !== ya) begin
      failures++;
      $display("FAIL noretrig_rearm got lat=%0d coord=%h/%h exp lat=%0d coord=%h/%h",
               lat, bus.X_COORD, bus.Y_COORD, LAT, xa, ya);
    end
    bus.Ena_trans = 1'b0;
  endtask

  task automatic test_abort();
    logic [11:0] px, py;
    int target;
    bit seen;
    px = bus.X_COORD; py = bus.Y_COORD;
    load_frames(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    target = 24 * (NFR / 2) + 12;
    bus.Ena_trans = 1'b0;
    @(posedge CLK); #1;
    bus.Ena_trans = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      if (rcount >= target) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL abort_reach_y_bit12 got=timeout exp=reached"); end
    done_cnt = 0;
    bus.Ena_trans = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({bus.ADC_DCLK, bus.ADC_DIN, bus.Busy} !== 3'b000) begin
      failures++; $display("FAIL abort_outputs got dclk/din/busy=%b exp=000",
                           {bus.ADC_DCLK, bus.ADC_DIN, bus.Busy});
    end
    repeat (400) @(posedge CLK);
    #1;
    checks++;
    if (done_cnt != 0 || bus.X_COORD !== px || bus.Y_COORD !== py) begin
      failures++; $display("FAIL abort_hold got done=%0d coord=%h/%h exp done=0 coord=%h/%h",
                           done_cnt, bus.X_COORD, bus.Y_COORD, px, py);
    end
  endtask

  task automatic test_boundary();
    int lat;
    tail_one = 1'b1;
    load_frames(12'hFFF, 12'hFFF, 12'h000, 12'h000);
    run_xfer(lat);
    checks++;
    if (lat != LAT || bus.X_COORD !== 12'hFFF || bus.Y_COORD !== 12'h000) begin
      failures++; $display("FAIL boundary got lat=%0d coord=%h/%h exp lat=%0d coord=fff/000",
                           lat, bus.X_COORD, bus.Y_COORD, LAT);
    end
    bus.Ena_trans = 1'b0;
    tail_one = 1'b0;
  endtask

`ifdef ADC_AVG_EN
  task automatic test_avg();
    int lat;
    load_frames(12'h100, 12'h103, 12'hFFF, 12'hFFE);
    run_xfer(lat);
    checks++;
    if (lat != 385 || bus.X_COORD !== 12'h101 || bus.Y_COORD !== 12'hFFE) begin
      failures++; $display("FAIL avg got lat=%0d coord=%h/%h exp lat=385 coord=101/ffe",
                           lat, bus.X_COORD, bus.Y_COORD);
    end
    bus.Ena_trans = 1'b0;
  endtask
`endif

  initial begin
    bus.Ena_trans = 1'b0;
    bus.ADC_DOUT  = 1'b0;
    test_reset();
    test_nominal();
    test_random();
    test_no_retrigger();
    test_abort();
    test_boundary();
`ifdef ADC_AVG_EN
    test_avg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_spi_xfer.md
# adc_spi_xfer

Serial transfer engine for the touch-screen ADC. Started by the ADC sequencer's `Ena_trans` level. Runs two 24-clock SPI frames: X channel, then Y channel. Each frame sends the command byte on `ADC_DIN` and captures the 12-bit result from `ADC_DOUT`. Both coordinates are published together with a one-cycle `Done` pulse, which drives the sequencer's transfer-complete inputs.

## Interface
Parameters:
- `CLK_DIV`, default 25: `CLK` cycles per DCLK half-period. Legal range 1..255.
- `CMD_X`, default 8'hD0: command byte for the X conversion (start=1, A2..A0=101, 12-bit, differential, PD=00).
- `CMD_Y`, default 8'h90: command byte for the Y conversion (A2..A0=001).

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST_n`  in  1  reset, asynchronous, active-low.
- `Ena_trans`  in  1  transfer request from the ADC sequencer; level-sensitive.
- `ADC_DOUT`  in  1  serial data from the ADC.
- `ADC_DCLK`  out  1  serial clock to the ADC.
- `ADC_DIN`  out  1  serial command data to the ADC.
- `X_COORD`  out  12  last complete X result.
- `Y_COORD`  out  12  last complete Y result.
- `Busy`  out  1  high while a frame is in progress.
- `Done`  out  1  one-cycle pulse when both coordinates have been updated.

## Operation
- States: IDLE, FRAME_X, FRAME_Y, DONE.
- Internal counters:
  - Divider: 8 bits, 0..CLK_DIV-1.
  - Bit index: 5 bits, 0..23.
  - Half flag: 0 = DCLK low, 1 = DCLK high.
- Arm flag:
  - Set whenever `Ena_trans`=0.
  - Set by reset.
  - Cleared on start.
- IDLE → FRAME_X when `Ena_trans`=1 and the arm flag is set. Divider, bit index and half flag clear.
- Within a frame, bit period k (0..23) is CLK_DIV cycles with DCLK low, then CLK_DIV cycles with DCLK high.
- `ADC_DIN` during bit k:
  - k=0..7: command bit 7-k, MSB first.
  - k=8..23: 0.
- `ADC_DOUT` is sampled in the cycle DCLK rises, for k=9..20. The bit is shifted into the 12-bit shadow register MSB first. k=8 is the ADC busy clock; k=21..23 are ignored.
- FRAME_X → FRAME_Y after the high half of bit 23, with counters cleared. The X shadow holds the result.
- FRAME_Y → DONE after the high half of bit 23.
- DONE lasts one cycle:
  - `X_COORD`/`Y_COORD` load from the shadows.
  - `Done`=1.
  - Next state is IDLE.
- Abort: `Ena_trans`=0 in FRAME_X or FRAME_Y forces IDLE on the next edge:
  - DCLK=0, DIN=0.
  - No `Done`.
  - `X_COORD`/`Y_COORD` unchanged.
- `Ena_trans` held high through DONE does not restart a transfer. It must drop for at least one cycle to re-arm.
- Reset (any time, including mid-frame): state IDLE, arm=1, all counters 0. Outputs at reset:
  - `ADC_DCLK`=0, `ADC_DIN`=0.
  - `X_COORD`=0, `Y_COORD`=0.
  - `Busy`=0, `Done`=0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start seen in IDLE at edge t → first DCLK low half begins at t+1. `Busy`=1 from t+1.
- One frame = 48·CLK_DIV cycles. DONE is entered 96·CLK_DIV cycles after t+1.
- In the DONE cycle:
  - `Done`=1.
  - `Busy`=0.
  - New coordinates are visible in that same cycle.
- Default CLK_DIV=25: `Done` at t+2401.
- DCLK duty is exactly 50%. DIN changes only coincident with a DCLK falling transition (start of a bit period).

## Configuration
- Macro `ADC_AVG_EN`.
- Defined:
  - Each axis is converted twice back-to-back. Sequence: X, X, Y, Y, four frames, using extra states FRAME_X2 and FRAME_Y2.
  - Published value = (first + second) >> 1, computed with a 13-bit sum and truncated.
  - `Done` latency becomes 192·CLK_DIV cycles after t+1.
  - Abort and re-arm rules are unchanged.
- Undefined: single conversion per axis, as described above.

## Test plan
- Reset then idle:
  - Stimulus: `RST_n`=0 mid-frame, then release with `Ena_trans`=0.
  - Response: all outputs 0, `Busy` stays 0, DCLK static low.
- Nominal transfer:
  - Stimulus: CLK_DIV=2, ADC model returns X=12'hA5C and Y=12'h3F1 on bits 9..20; `Ena_trans` rises at t.
  - Response:
    - DIN carries D0 then 90, MSB first.
    - 48 DCLK rising edges.
    - `Done` one cycle at t+193.
    - `X_COORD`=A5C, `Y_COORD`=3F1.
- No retrigger: hold `Ena_trans`=1 for 500 cycles → exactly one `Done`. Drop for 1 cycle, raise again → second transfer starts.
- Abort:
  - Stimulus: drop `Ena_trans` during FRAME_Y bit 12.
  - Response:
    - Next cycle DCLK=0, DIN=0, `Busy`=0.
    - No `Done`.
    - Coordinates keep previous values.
- Boundary data: ADC returns 12'hFFF then 12'h000 → coordinates FFF/000 exactly; bits 21..23 driven 1 are ignored.
- With `ADC_AVG_EN`:
  - Stimulus: X samples 12'h100 and 12'h103; Y samples 12'hFFF and 12'hFFE.
  - Response: `X_COORD`=101, `Y_COORD`=FFE; `Done` at t+385 with CLK_DIV=2.
